uart_bcd_reporter: RTL and testbench

Parametrised successor to the single-field seconds reporter. Formats NUM_FIELDS packed BCD bytes into an ASCII line, e.g. "TIME: 12:34:56\r\n", and streams it byte by byte over a valid/ready interface into the existing uart_tx.
Supports periodic, on-change, triggered and disabled modes. All fields are snapshotted at frame start, so a frame is never torn.
Sits between the RTC/counter blocks (ds1302 reader) and uart_tx.

---
 rtl/uart_fmt_pkg.sv | 30 +++
 rtl/uart_frame_rom.sv | 55 +++++
 rtl/uart_bcd_reporter.sv | 141 ++++++++++++++
 tb/tb_uart_bcd_reporter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fmt_pkg.sv
// Shared types and helpers for the BCD line reporter.
// Contents: FSM state enum, ASCII constants, byte-index width,
// nibble-to-ASCII conversion and frame-length calculation.
package uart_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } state_t;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] ZERO  = 8'h30;

  // Longest frame is 16 prefix + 8 fields * 3 - 1 + CR/LF = 41 bytes.
  localparam int IDX_W = 6;

  // Nibbles 10-15 are not valid BCD; print '?' so bad data is visible.
  function automatic logic [7:0] bcd_nib_to_ascii(input logic [3:0] nib);
    return (nib <= 4'd9) ? (ZERO + {4'h0, nib}) : QMARK;
  endfunction

  function automatic int frame_len(input int prefix_len, input int num_fields);
    return prefix_len + 3 * num_fields - 1 + 2;
  endfunction

endpackage

// File: rtl/uart_frame_rom.sv
// Combinational character generator for one report line.
// Ports:
//   idx       in   byte position within the frame
//   snapshot  in   packed BCD fields, field 0 at the MSBs
//   char_out  out  ASCII byte for position idx
module uart_frame_rom
  import uart_fmt_pkg::*;
#(
  parameter int           NUM_FIELDS = 3,
  parameter int           PREFIX_LEN = 6,
  parameter logic [127:0] PREFIX     = "TIME: ",
  parameter logic [7:0]   SEP_CHAR   = 8'h3A
) (
  input  logic [IDX_W-1:0]        idx,
  input  logic [NUM_FIELDS*8-1:0] snapshot,
  output logic [7:0]              char_out
);

  localparam int FLEN      = frame_len(PREFIX_LEN, NUM_FIELDS);
  localparam int FIELD_END = PREFIX_LEN + 3 * NUM_FIELDS - 1;

  // String literals are right-justified; shift so the first prefix
  // character always sits in bits 127:120 regardless of PREFIX_LEN.
  localparam logic [127:0] PFX_AL = PREFIX << (8 * (16 - PREFIX_LEN));

  logic [IDX_W-1:0] rel;
  logic [3:0]       pfx_pos;
  logic [7:0]       fbyte;

  always_comb begin
    char_out = 8'h00;
    rel      = idx - IDX_W'(PREFIX_LEN);
    pfx_pos  = idx[3:0];
    fbyte    = 8'h00;
    if (idx < IDX_W'(PREFIX_LEN)) begin
      // 15 - pfx_pos == ~pfx_pos for a 4-bit value
      char_out = PFX_AL[{~pfx_pos, 3'b000} +: 8];
    end else if (idx < IDX_W'(FIELD_END)) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        fbyte = snapshot[(NUM_FIELDS-1-f)*8 +: 8];
        if (rel == IDX_W'(3 * f))
          char_out = bcd_nib_to_ascii(fbyte[7:4]);
        else if (rel == IDX_W'(3 * f + 1))
          char_out = bcd_nib_to_ascii(fbyte[3:0]);
        else if (rel == IDX_W'(3 * f + 2))
          char_out = SEP_CHAR;
      end
    end else if (idx == IDX_W'(FLEN - 2)) begin
      char_out = CR;
    end else if (idx == IDX_W'(FLEN - 1)) begin
      char_out = LF;
    end
  end

endmodule

// File: rtl/uart_bcd_reporter.sv
// Formats NUM_FIELDS packed BCD bytes into an ASCII line
// ("TIME: 12:34:56\r\n") and streams it over valid/ready to uart_tx.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mode         0 periodic, 1 on-change, 2 triggered, 3 disabled
//   send_req     single-cycle trigger request (ignored in mode 3)
//   field_data   packed BCD, field 0 at MSBs, printed first
//   tx_data      byte to uart_tx
//   tx_valid     tx_data valid
//   tx_ready     uart_tx accepts the byte
//   busy         frame in progress (LOAD or SEND)
//   frame_done   one-cycle pulse after the last byte is accepted
//
// state | meaning
// IDLE  | post-reset; starts at once in mode 0, else acts as WAIT
// LOAD  | snapshot field_data, rewind byte index
// SEND  | stream frame bytes on the handshake
// WAIT  | between frames, evaluating the start condition
module uart_bcd_reporter
  import uart_fmt_pkg::*;
#(
  parameter int           PERIOD_CYCLES = 50_000_000,
  parameter int           NUM_FIELDS    = 3,
  parameter int           PREFIX_LEN    = 6,
  parameter logic [127:0] PREFIX        = "TIME: ",
  parameter logic [7:0]   SEP_CHAR      = 8'h3A
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic                    send_req,
  input  logic [NUM_FIELDS*8-1:0] field_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int               FLEN   = frame_len(PREFIX_LEN, NUM_FIELDS);
  localparam int               TW     = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [TW-1:0]    T_LAST = TW'(PERIOD_CYCLES - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(FLEN - 1);

  state_t                  state, state_nx;
  logic [TW-1:0]           timer;
  logic [IDX_W-1:0]        idx;
  logic                    pending;
  logic [NUM_FIELDS*8-1:0] snapshot;
  logic [NUM_FIELDS*8-1:0] last_sent;
  logic                    start;
  logic                    last_xfer;
  logic [7:0]              rom_char;

  uart_frame_rom #(
    .NUM_FIELDS (NUM_FIELDS),
    .PREFIX_LEN (PREFIX_LEN),
    .PREFIX     (PREFIX),
    .SEP_CHAR   (SEP_CHAR)
  ) u_rom (
    .idx      (idx),
    .snapshot (snapshot),
    .char_out (rom_char)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    start     = 1'b0;
    state_nx  = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = 1'b0;
    last_xfer = 1'b0;

    case (mode)
      2'd0:    start = (timer == T_LAST) || send_req || pending;
      2'd1:    start = (field_data != last_sent) || send_req || pending;
      2'd2:    start = send_req || pending;
      default: start = 1'b0;
    endcase
    // First frame after reset goes out without waiting a full period.
    if (state == IDLE && mode == 2'd0) start = 1'b1;

    case (state)
      IDLE, WAIT: if (start) state_nx = LOAD;
      LOAD: begin
        busy     = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = rom_char;
        last_xfer = tx_ready && (idx == I_LAST);
        if (last_xfer) state_nx = WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      snapshot   <= '0;
      last_sent  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_xfer;
      case (state)
        IDLE, WAIT: begin
          if (start) pending <= 1'b0;
          if (timer != T_LAST) timer <= timer + 1'b1;
        end
        LOAD: begin
          snapshot <= field_data;
          idx      <= '0;
          if (send_req) pending <= 1'b1;
        end
        SEND: begin
          if (send_req) pending <= 1'b1;
          if (tx_ready) begin
            if (last_xfer) begin
              last_sent <= snapshot;
              timer     <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bcd_reporter.sv
// Scoreboard bench for uart_bcd_reporter: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every accepted byte and checks
// frame_done follows the LF transfer.
module tb_uart_bcd_reporter;

  localparam int PERIOD = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode;
  logic        send_req;
  logic [23:0] field_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  uart_bcd_reporter #(
    .PERIOD_CYCLES (PERIOD),
    .NUM_FIELDS    (3),
    .PREFIX_LEN    (6),
    .PREFIX        ("TIME: "),
    .SEP_CHAR      (8'h3A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .send_req   (send_req),
    .field_data (field_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  function automatic void push_frame(input string body);
    push_str("TIME: ");
    push_str(body);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    send_req = 1'b1;
    step(1);
    send_req = 1'b0;
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 2000) begin
      step(1);
      n++;
    end
    check("wait_bytes_timeout", acc_cnt >= target, 1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      step(1);
      n++;
    end
    check("wait_frame_timeout", done_cnt >= target, 1);
  endtask

  // Monitor
  initial begin
    logic [7:0] e;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_last = 1'b0;
      end else begin
        if (frame_done || prev_last) begin
          check("frame_done", frame_done, prev_last);
          if (frame_done) done_cnt++;
        end
        prev_last = 1'b0;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got %02h, expected no traffic (t=%0t)", tx_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", tx_data, e);
          end
          acc_cnt++;
          prev_last = (tx_data == 8'h0A);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    mode       = 2'd0;
    send_req   = 1'b0;
    field_data = 24'h123456;
    tx_ready   = 1'b1;
    rst_n      = 1'b0;
    #23;
    check("rst_tx_valid",   tx_valid,   0);
    check("rst_tx_data",    tx_data,    0);
    check("rst_busy",       busy,       0);
    check("rst_frame_done", frame_done, 0);

    // 1: periodic, two frames, gap measured from frame_done
    push_frame("12:34:56");
    push_frame("12:34:56");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_done(1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 300);
    // timer reaches PERIOD-1 after PERIOD-1 WAIT edges, then LOAD, then SEND
    check("period_gap", n, PERIOD + 1);

    // 2: stall on the '3' of the second frame
    wait_acc(16 + 9);
    tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", tx_valid, 1);
      check("stall_data",  tx_data,  8'h33);
      check("stall_busy",  busy,     1);
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    wait_done(2);
    mode = 2'd3;

    // 3: on-change
    push_frame("00:00:59");
    field_data = 24'h000059;
    mode = 2'd1;
    wait_done(3);
    step(30);
    check("onchange_quiet1", done_cnt, 3);
    push_frame("00:01:00");
    field_data = 24'h000100;
    wait_done(4);
    step(30);
    check("onchange_quiet2", done_cnt, 4);
    check("onchange_bytes",  acc_cnt,  64);

    // 4: triggered with merged pending requests, then disabled
    mode = 2'd2;
    push_frame("00:01:00");
    pulse_req();
    wait_acc(64 + 3);
    pulse_req();
    step(2);
    pulse_req();
    step(2);
    pulse_req();
    push_frame("00:01:00");
    wait_done(6);
    step(40);
    check("pending_frames", done_cnt, 6);
    check("pending_bytes",  acc_cnt,  96);
    mode = 2'd3;
    pulse_req();
    step(40);
    check("disabled_frames", done_cnt, 6);
    check("disabled_bytes",  acc_cnt,  96);

    // 5: invalid BCD nibble, data change during SEND
    mode = 2'd2;
    field_data = 24'h1A0000;
    push_frame("1?:00:00");
    pulse_req();
    wait_acc(96 + 4);
    field_data = 24'h999999;
    wait_done(7);
    step(10);
    check("snapshot_frames", done_cnt, 7);

    // 6: async reset mid-frame, fresh frame after release
    mode = 2'd0;
    field_data = 24'h123456;
    push_frame("12:34:56");
    pulse_req();
    wait_acc(112 + 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid",   tx_valid,   0);
    check("mid_rst_busy",       busy,       0);
    check("mid_rst_tx_data",    tx_data,    0);
    check("mid_rst_frame_done", frame_done, 0);
    exp_q.delete();
    push_frame("12:34:56");
    step(2);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!tx_valid && n < 10);
    check("restart_edge", n, 2);
    wait_done(8);
    mode = 2'd3;
    step(20);
    check("queue_empty", exp_q.size(), 0);
    check("total_bytes", acc_cnt, 133);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
